// File: rtl/vx_axi_write_arb.sv
// rtl/vx_axi_write_arb.sv - N-to-1 AXI4 write-channel arbiter with in-order W steering
// Round-robin AW grants tag the ID with the input index; a grant FIFO orders W bursts; B is routed by index.
module vx_axi_write_arb #(
  parameter int NUM_INPUTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int SEL_POS    = 0,
  parameter int GNT_DEPTH  = 4,
  localparam int SELW  = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1,
  localparam int MIDW  = ID_WIDTH + SELW,
  localparam int STRBW = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_INPUTS-1:0]            s_awvalid,
  output logic [NUM_INPUTS-1:0]            s_awready,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_INPUTS*ID_WIDTH-1:0]   s_awid,
  input  logic [NUM_INPUTS*8-1:0]          s_awlen,
  input  logic [NUM_INPUTS*3-1:0]          s_awsize,
  input  logic [NUM_INPUTS*2-1:0]          s_awburst,
  input  logic [NUM_INPUTS-1:0]            s_wvalid,
  output logic [NUM_INPUTS-1:0]            s_wready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_INPUTS*STRBW-1:0]      s_wstrb,
  input  logic [NUM_INPUTS-1:0]            s_wlast,
  output logic [NUM_INPUTS-1:0]            s_bvalid,
  input  logic [NUM_INPUTS-1:0]            s_bready,
  output logic [NUM_INPUTS*ID_WIDTH-1:0]   s_bid,
  output logic [NUM_INPUTS*2-1:0]          s_bresp,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [MIDW-1:0]                  m_awid,
  output logic [7:0]                       m_awlen,
  output logic [2:0]                       m_awsize,
  output logic [1:0]                       m_awburst,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [STRBW-1:0]                 m_wstrb,
  output logic                             m_wlast,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  input  logic [MIDW-1:0]                  m_bid,
  input  logic [1:0]                       m_bresp,
  output logic                             err_bsel
);

  localparam int PW = (GNT_DEPTH > 1) ? $clog2(GNT_DEPTH) : 1;
  localparam int CW = $clog2(GNT_DEPTH + 1);
  localparam logic [MIDW:0]   ONE_SHL = (MIDW+1)'(1) << SEL_POS;
  localparam logic [MIDW-1:0] LO_MASK = MIDW'(ONE_SHL - (MIDW+1)'(1));

  logic [SELW-1:0] last_q, last_d, lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic [SELW-1:0] mem_q [GNT_DEPTH];
  logic [SELW-1:0] mem_d [GNT_DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            full, empty, aw_hs, w_pop, bad_sel;
  logic [SELW-1:0] rr_idx, gnt, head, sel;
  logic [MIDW-1:0] awid_ext, gnt_ext;
  logic [ID_WIDTH-1:0] bid_strip;

  assign full  = (cnt_q == CW'(GNT_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    int   cand;
    logic found;
    cand   = 0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = (int'(last_q) + k) % NUM_INPUTS;
      if (!found && s_awvalid[cand]) begin
        found  = 1'b1;
        rr_idx = SELW'(cand);
      end
    end
  end

  assign gnt       = lock_q ? lock_idx_q : rr_idx;
  assign m_awvalid = (|s_awvalid) & ~full;
  assign aw_hs     = m_awvalid & m_awready;
  assign s_awready = aw_hs ? (NUM_INPUTS'(1) << gnt) : '0;

  assign m_awaddr  = s_awaddr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_awlen   = s_awlen[int'(gnt)*8 +: 8];
  assign m_awsize  = s_awsize[int'(gnt)*3 +: 3];
  assign m_awburst = s_awburst[int'(gnt)*2 +: 2];
  assign awid_ext  = MIDW'(s_awid[int'(gnt)*ID_WIDTH +: ID_WIDTH]);
  assign gnt_ext   = MIDW'(gnt);
  assign m_awid    = (awid_ext & LO_MASK) | (gnt_ext << SEL_POS) | ((awid_ext & ~LO_MASK) << SELW);

  assign m_wvalid = ~empty & s_wvalid[head];
  assign m_wdata  = s_wdata[int'(head)*DATA_WIDTH +: DATA_WIDTH];
  assign m_wstrb  = s_wstrb[int'(head)*STRBW +: STRBW];
  assign m_wlast  = s_wlast[head];
  assign s_wready = empty ? '0 : (NUM_INPUTS'(m_wready) << head);
  assign w_pop    = m_wvalid & m_wready & m_wlast;

  assign sel       = SELW'(m_bid >> SEL_POS);
  assign bad_sel   = int'(sel) >= NUM_INPUTS;
  assign bid_strip = ID_WIDTH'((m_bid & LO_MASK) | ((m_bid >> SELW) & ~LO_MASK));
  assign s_bid     = {NUM_INPUTS{bid_strip}};
  assign s_bresp   = {NUM_INPUTS{m_bresp}};
  assign err_bsel  = err_q;

  // Responses with an out-of-range index are accepted and discarded.
  always_comb begin
    s_bvalid = '0;
    m_bready = bad_sel;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!bad_sel && sel == SELW'(i)) begin
        s_bvalid[i] = m_bvalid;
        m_bready    = s_bready[i];
      end
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    err_d      = err_q | (m_bvalid & bad_sel);
    if (aw_hs) begin
      lock_d      = 1'b0;
      last_d      = gnt;
      mem_d[wr_q] = gnt;
      wr_d        = (wr_q == PW'(GNT_DEPTH-1)) ? '0 : wr_q + PW'(1);
    end else if (m_awvalid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end
    if (w_pop) begin
      rd_d = (rd_q == PW'(GNT_DEPTH-1)) ? '0 : rd_q + PW'(1);
    end
    case ({aw_hs, w_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_q     <= SELW'(NUM_INPUTS-1);
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

endmodule
